spu_regfile_mp: RTL and testbench

- Parametrised multi-port SPU register file for the dual-issue pipeline.
- Generalises the fixed 128x128, 5-read/2-write register file to configurable depth, width and port counts.
- Adds a sequenced post-reset clear, deterministic same-address write-conflict resolution with a per-port replay buffer and stall, and optional write-through bypass.
- Sits between decode/operand fetch (read ports) and the even/odd writeback stages (write ports).

---
 rtl/spu_regfile_mp.sv | 164 ++++++++++++++++
 tb/tb_spu_regfile_mp.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_regfile_mp.sv
// rtl/spu_regfile_mp.sv - parametrised multi-port SPU register file with post-reset clear and write replay
//
// Purpose: NUM_REGS x DATA_W register file for the dual-issue pipeline. It has NUM_RD
// combinational read ports and NUM_WR write ports. Same-address write conflicts are
// resolved by priority: a losing new write parks in its port's replay slot and stalls
// that port until the slot commits. After reset the whole array is cleared, one entry
// per cycle, before normal operation starts.
//
// Ports:
//   clock      sole clock, rising edge
//   reset      asynchronous, active-high
//   rd_addr    packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    packed read data, port i at [i*DATA_W +: DATA_W]
//   wr_en      per-port write enable (port 0 = even pipe, highest priority)
//   wr_addr    packed write addresses
//   wr_data    packed write data
//   wr_stall   per-port "replay pending"; upstream holds wr_en[p]=0 while high
//   init_busy  post-reset clear in progress
//
// Optional feature: define SPU_REGFILE_BYPASS_EN for write-through read bypass.

module spu_regfile_mp #(
    parameter int NUM_REGS = 128,
    parameter int DATA_W   = 128,
    parameter int ADDR_W   = 7,
    parameter int NUM_RD   = 5,
    parameter int NUM_WR   = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    output logic [NUM_WR-1:0]          wr_stall,
    output logic                       init_busy
);

    // Candidates 0..NUM_WR-1 are replay slots, NUM_WR..2*NUM_WR-1 are new writes;
    // a lower candidate index means a higher commit priority.
    localparam int                NUM_CAND   = 2 * NUM_WR;
    localparam logic [ADDR_W:0]   REGS_LIMIT = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_REG   = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [NUM_WR-1:0] rep_valid;
    logic [ADDR_W-1:0] rep_addr [NUM_WR];
    logic [DATA_W-1:0] rep_data [NUM_WR];
    logic [DATA_W-1:0] mem      [NUM_REGS];

    logic              cand_v   [NUM_CAND];
    logic [ADDR_W-1:0] cand_a   [NUM_CAND];
    logic [DATA_W-1:0] cand_d   [NUM_CAND];
    logic              win      [NUM_CAND];
    logic [NUM_WR-1:0] new_v;
    logic [ADDR_W-1:0] rd_idx   [NUM_RD];

    // Candidate collection and per-address arbitration.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            // A new write is eligible only in RUN, while its port is not stalled
            // (a write during a stall is a protocol violation and is dropped),
            // and only to an existing register (out-of-range writes vanish).
            new_v[p] = (state == ST_RUN) && wr_en[p] && !rep_valid[p] &&
                       ({1'b0, wr_addr[p*ADDR_W +: ADDR_W]} < REGS_LIMIT);

            cand_v[p]          = (state == ST_RUN) && rep_valid[p];
            cand_a[p]          = rep_addr[p];
            cand_d[p]          = rep_data[p];
            cand_v[NUM_WR + p] = new_v[p];
            cand_a[NUM_WR + p] = wr_addr[p*ADDR_W +: ADDR_W];
            cand_d[NUM_WR + p] = wr_data[p*DATA_W +: DATA_W];
        end
        for (int c = 0; c < NUM_CAND; c++) begin
            win[c] = cand_v[c];
            for (int j = 0; j < c; j++) begin
                if (cand_v[j] && (cand_a[j] == cand_a[c])) begin
                    win[c] = 1'b0;
                end
            end
        end
    end

    // Combinational read ports. At most one winner exists per address, so the
    // bypass scan order does not matter; losers are never forwarded.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_idx[i] = rd_addr[i*ADDR_W +: ADDR_W];
            if ((state == ST_RUN) && ({1'b0, rd_idx[i]} < REGS_LIMIT)) begin
                rd_data[i*DATA_W +: DATA_W] = mem[rd_idx[i]];
`ifdef SPU_REGFILE_BYPASS_EN
                for (int c = 0; c < NUM_CAND; c++) begin
                    if (win[c] && (cand_a[c] == rd_idx[i])) begin
                        rd_data[i*DATA_W +: DATA_W] = cand_d[c];
                    end
                end
`endif
            end
        end
    end

    // Storage array: not reset by its flops; the INIT sweep clears it instead.
    always_ff @(posedge clock) begin
        if (state == ST_INIT) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int c = 0; c < NUM_CAND; c++) begin
                if (win[c]) begin
                    mem[cand_a[c]] <= cand_d[c];
                end
            end
        end
    end

    // Control: clear sequencer and replay slots.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            clr_cnt   <= '0;
            init_busy <= 1'b1;
            rep_valid <= '0;
            for (int p = 0; p < NUM_WR; p++) begin
                rep_addr[p] <= '0;
                rep_data[p] <= '0;
            end
        end else begin
            case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == LAST_REG) begin
                        state     <= ST_RUN;
                        init_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    for (int p = 0; p < NUM_WR; p++) begin
                        if (rep_valid[p] && win[p]) begin
                            rep_valid[p] <= 1'b0;
                        end
                        // new_v implies the slot was empty, so capture never
                        // collides with a retained replay.
                        if (new_v[p] && !win[NUM_WR + p]) begin
                            rep_valid[p] <= 1'b1;
                            rep_addr[p]  <= wr_addr[p*ADDR_W +: ADDR_W];
                            rep_data[p]  <= wr_data[p*DATA_W +: DATA_W];
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign wr_stall = rep_valid;

endmodule

// File: tb/tb_spu_regfile_mp.sv
// tb/tb_spu_regfile_mp.sv - self-checking bench for spu_regfile_mp

module tb_spu_regfile_mp;

    localparam int NR  = 128;
    localparam int DW  = 128;
    localparam int AW  = 7;
    localparam int NRD = 5;
    localparam int NWR = 2;

    logic                clock = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*DW-1:0]   rd_data;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*DW-1:0]   wr_data;
    logic [NWR-1:0]      wr_stall;
    logic                init_busy;

    int n_tests = 0;
    int n_fail  = 0;

    spu_regfile_mp #(
        .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_stall  (wr_stall),
        .init_busy (init_busy)
    );

    always #5 clock = ~clock;

    // Reference model: register contents, clear progress and pending deferred writes.
    logic [DW-1:0] m_mem [NR];
    bit            m_init;
    int            m_cnt;
    bit            m_rv   [NWR];
    int            m_ra   [NWR];
    logic [DW-1:0] m_rd   [NWR];
    // What the coming clock edge will do.
    bit            p_take [NR];
    logic [DW-1:0] p_data [NR];
    bit            p_rv   [NWR];
    int            p_ra   [NWR];
    logic [DW-1:0] p_rd   [NWR];

    function automatic void model_reset();
        m_init = 1'b1;
        m_cnt  = 0;
        for (int p = 0; p < NWR; p++) m_rv[p] = 1'b0;
    endfunction

    // Deferred writes claim their registers first, then new writes in port order;
    // a new write finding its register already claimed is deferred.
    function automatic void model_plan();
        for (int a = 0; a < NR; a++) p_take[a] = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            p_rv[p] = m_rv[p]; p_ra[p] = m_ra[p]; p_rd[p] = m_rd[p];
        end
        if (m_init) return;
        for (int p = 0; p < NWR; p++) begin
            if (m_rv[p] && !p_take[m_ra[p]]) begin
                p_take[m_ra[p]] = 1'b1;
                p_data[m_ra[p]] = m_rd[p];
                p_rv[p]         = 1'b0;
            end
        end
        for (int p = 0; p < NWR; p++) begin
            int a;
            a = int'(wr_addr[p*AW +: AW]);
            if (wr_en[p] && !m_rv[p] && a < NR) begin
                if (!p_take[a]) begin
                    p_take[a] = 1'b1;
                    p_data[a] = wr_data[p*DW +: DW];
                end else begin
                    p_rv[p] = 1'b1;
                    p_ra[p] = a;
                    p_rd[p] = wr_data[p*DW +: DW];
                end
            end
        end
    endfunction

    function automatic void model_commit();
        if (m_init) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == NR) m_init = 1'b0;
        end else begin
            for (int a = 0; a < NR; a++) if (p_take[a]) m_mem[a] = p_data[a];
            for (int p = 0; p < NWR; p++) begin
                m_rv[p] = p_rv[p]; m_ra[p] = p_ra[p]; m_rd[p] = p_rd[p];
            end
        end
    endfunction

    function automatic logic [DW-1:0] exp_rd(int i);
        int a;
        a = int'(rd_addr[i*AW +: AW]);
        if (m_init || a >= NR) return '0;
`ifdef SPU_REGFILE_BYPASS_EN
        if (p_take[a]) return p_data[a];
`endif
        return m_mem[a];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: inputs are already applied; check outputs against the model,
    // then let the edge happen and advance the model.
    task automatic cycle();
        #1;
        model_plan();
        check("init_busy", DW'(init_busy), DW'(m_init));
        for (int p = 0; p < NWR; p++) check($sformatf("wr_stall%0d", p), DW'(wr_stall[p]), DW'(m_rv[p]));
        for (int i = 0; i < NRD; i++) check($sformatf("rd_data%0d", i), rd_data[i*DW +: DW], exp_rd(i));
        @(posedge clock);
        model_commit();
        #1;
    endtask

    task automatic set_wr(input int p, input logic en, input int a, input logic [DW-1:0] d);
        wr_en[p]          = en;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int i, input int a);
        rd_addr[i*AW +: AW] = AW'(a);
    endtask

    initial begin
        reset   = 1'b1;
        rd_addr = '0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        model_reset();

        // Reset state.
        #2;
        check("reset_init_busy", DW'(init_busy), DW'(1));
        check("reset_wr_stall", DW'(wr_stall), DW'(0));
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;

        // Clear sweep; writes attempted during it must be ignored.
        for (int k = 0; k < NR; k++) begin
            if (k == 3 || k == 100) set_wr(0, 1'b1, 7, {32{4'hF}});
            else wr_en = '0;
            for (int i = 0; i < NRD; i++) set_rd(i, 7);
            cycle();
        end
        wr_en = '0;
        check("init_done", DW'(init_busy), DW'(0));
        set_rd(0, 7);
        #1;
        check("init_wr_ignored", rd_data[0 +: DW], '0);

        // Every register reads zero after the clear.
        for (int k = 0; k < (NR + NRD - 1) / NRD; k++) begin
            for (int i = 0; i < NRD; i++) set_rd(i, (k * NRD + i) % NR);
            cycle();
        end

        // Two ports, different addresses, same cycle.
        set_wr(0, 1'b1, 5, {32{4'hA}});
        set_wr(1, 1'b1, 9, {32{4'h5}});
        set_rd(0, 5); set_rd(1, 9);
        cycle();
        wr_en = '0;
        #1;
        check("r5", rd_data[0 +: DW], {32{4'hA}});
        check("r9", rd_data[DW +: DW], {32{4'h5}});
        check("no_stall", DW'(wr_stall), DW'(0));
        cycle();

        // Same-address collision: even value first, odd value final.
        set_wr(0, 1'b1, 12, 128'h1);
        set_wr(1, 1'b1, 12, 128'h2);
        set_rd(0, 12);
        cycle();
        wr_en = '0;
        #1;
        check("r12_first", rd_data[0 +: DW], 128'h1);
        check("r12_stall", DW'(wr_stall), DW'(2'b10));
        cycle();
        check("r12_final", rd_data[0 +: DW], 128'h2);
        check("r12_stall_clr", DW'(wr_stall), DW'(0));

        // Pending port-1 replay beats a new port-0 write to the same register.
        set_wr(0, 1'b1, 20, 128'h11);
        set_wr(1, 1'b1, 20, 128'h22);
        set_rd(0, 20);
        cycle();
        set_wr(0, 1'b1, 20, 128'h7);
        wr_en[1] = 1'b0;
        cycle();
        wr_en = '0;
        #1;
        check("r20_replay", rd_data[0 +: DW], 128'h22);
        check("r20_stall0", DW'(wr_stall), DW'(2'b01));
        cycle();
        check("r20_final", rd_data[0 +: DW], 128'h7);
        check("r20_stall_clr", DW'(wr_stall), DW'(0));

        // Write-through visibility.
        set_wr(0, 1'b1, 3, 128'hDEAD);
        set_rd(0, 3);
        #1;
`ifdef SPU_REGFILE_BYPASS_EN
        check("r3_same_cycle", rd_data[0 +: DW], 128'hDEAD);
`else
        check("r3_same_cycle", rd_data[0 +: DW], 128'h0);
`endif
        cycle();
        wr_en = '0;
        #1;
        check("r3_next_cycle", rd_data[0 +: DW], 128'hDEAD);
        cycle();

        // Randomised traffic in a small address window to force collisions;
        // occasional writes during a stall exercise the ignore rule.
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < NWR; p++) begin
                logic en;
                en = ($urandom_range(0, 99) < 60);
                if (m_rv[p] && $urandom_range(0, 7) != 0) en = 1'b0;
                set_wr(p, en, $urandom_range(0, 15), {$urandom, $urandom, $urandom, $urandom});
            end
            for (int i = 0; i < NRD; i++) set_rd(i, $urandom_range(0, 15));
            cycle();
        end
        wr_en = '0;
        cycle(); cycle();

        // Reset while a replay is pending.
        set_wr(0, 1'b1, 40, 128'hBEEF);
        set_wr(1, 1'b1, 40, 128'hCAFE);
        set_rd(0, 40);
        cycle();
        wr_en = '0;
        #1;
        check("pre_reset_stall", DW'(wr_stall), DW'(2'b10));
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_stall_clr", DW'(wr_stall), DW'(0));
        check("async_init_busy", DW'(init_busy), DW'(1));
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < NR; k++) cycle();
        set_rd(0, 40);
        #1;
        check("r40_cleared", rd_data[0 +: DW], '0);
        check("reinit_done", DW'(init_busy), DW'(0));
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
